// File: rtl/led_key_pio_pkg.sv
// led_key_pio_pkg: register map and control bit constants for the LED/key peripheral
package led_key_pio_pkg;
  localparam int ADDR_CTRL       = 0;
  localparam int ADDR_LED_DIRECT = 1;
  localparam int ADDR_KEY_STATE  = 2;
  localparam int ADDR_EDGE_CAP   = 3;
  localparam int ADDR_IRQ_MASK   = 4;
  localparam int ADDR_DUTY_BASE  = 5;
  localparam int CTRL_EN         = 0;
  localparam int CTRL_MODE       = 1;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser plus stable-count debouncer for one active-low key
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  logic s1, s2, in_lvl, done;
  logic [CW-1:0] cnt;
  assign in_lvl = ~s2;
  assign done   = cnt == CW'(DEBOUNCE_CYCLES - 1);
  assign press  = in_lvl & ~level & done;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1    <= 1'b1;
      s2    <= 1'b1;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      s1    <= key_n;
      s2    <= s1;
      level <= (in_lvl != level && done) ? in_lvl : level;
      cnt   <= (in_lvl == level || done) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/led_key_pio.sv
// led_key_pio: Avalon-MM LED (direct/PWM) and debounced key peripheral with edge capture and IRQ
module led_key_pio
  import led_key_pio_pkg::*;
#(
  parameter int NUM_LEDS        = 4,
  parameter int NUM_KEYS        = 4,
  parameter int PWM_BITS        = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int ADDR_W          = 5
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [ADDR_W-1:0]   avs_address,
  input  logic                avs_read,
  input  logic                avs_write,
  input  logic [31:0]         avs_writedata,
  output logic [31:0]         avs_readdata,
  output logic                avs_readdatavalid,
  input  logic [NUM_KEYS-1:0] key_n,
  output logic [NUM_LEDS-1:0] led,
  output logic                irq
);
  logic [31:0] a, rd;
  logic [1:0] ctrl;
  logic [NUM_LEDS-1:0] led_direct, pwm;
  logic [NUM_KEYS-1:0] key_state, press, edge_cap, irq_mask;
  logic [NUM_LEDS-1:0][PWM_BITS-1:0] duty, shadow;
  logic [PWM_BITS-1:0] cnt;
  logic unused_ok;
  assign a = 32'(avs_address);
  assign unused_ok = ^avs_writedata;
  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk(clk_clk),
      .rst_n(reset_reset_n),
      .key_n(key_n[k]),
      .level(key_state[k]),
      .press(press[k])
    );
  end
  always_comb begin
    pwm = '0;
    for (int i = 0; i < NUM_LEDS; i++) pwm[i] = cnt < shadow[i];
  end
  always_comb begin
    rd = '0;
    if (a == ADDR_CTRL) rd[1:0] = ctrl;
    if (a == ADDR_LED_DIRECT) rd[NUM_LEDS-1:0] = led_direct;
    if (a == ADDR_KEY_STATE) rd[NUM_KEYS-1:0] = key_state;
    if (a == ADDR_EDGE_CAP) rd[NUM_KEYS-1:0] = edge_cap;
    if (a == ADDR_IRQ_MASK) rd[NUM_KEYS-1:0] = irq_mask;
    for (int i = 0; i < NUM_LEDS; i++) if (a == ADDR_DUTY_BASE + i) rd[PWM_BITS-1:0] = duty[i];
  end
  // shadow duties load as the counter wraps so a period never sees a half-applied duty
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      ctrl              <= '0;
      led_direct        <= '0;
      edge_cap          <= '0;
      irq_mask          <= '0;
      duty              <= '0;
      shadow            <= '0;
      cnt               <= '0;
      led               <= '0;
      irq               <= 1'b0;
      avs_readdata      <= '0;
      avs_readdatavalid <= 1'b0;
    end else begin
      if (avs_write && a == ADDR_CTRL) ctrl <= avs_writedata[1:0];
      if (avs_write && a == ADDR_LED_DIRECT) led_direct <= avs_writedata[NUM_LEDS-1:0];
      if (avs_write && a == ADDR_IRQ_MASK) irq_mask <= avs_writedata[NUM_KEYS-1:0];
      for (int i = 0; i < NUM_LEDS; i++)
        if (avs_write && a == ADDR_DUTY_BASE + i) duty[i] <= avs_writedata[PWM_BITS-1:0];
      edge_cap          <= (edge_cap & ~((avs_write && a == ADDR_EDGE_CAP) ? avs_writedata[NUM_KEYS-1:0] : '0)) | press;
      cnt               <= cnt + 1'b1;
      shadow            <= &cnt ? duty : shadow;
      led               <= ctrl[CTRL_EN] ? (ctrl[CTRL_MODE] ? pwm : led_direct) : '0;
      irq               <= |(edge_cap & irq_mask);
      avs_readdatavalid <= avs_read;
      avs_readdata      <= avs_read ? rd : '0;
    end
endmodule

// File: doc/led_key_pio.md
Name: led_key_pio

Overview:
- Parametrised LED/key peripheral on an Avalon-MM slave, instantiated inside the HPS/FPGA system.
- Replaces the fixed 4-bit LED test export.
- Provides per-channel direct or PWM LED drive, debounced key inputs, edge capture and a maskable interrupt.
- The HPS software controls the LEDs and polls or takes interrupts from the keys.

Parameters:
- NUM_LEDS, 4, number of LED channels (1..16).
- NUM_KEYS, 4, number of key inputs (1..16).
- PWM_BITS, 8, PWM counter and duty width (1..16).
- DEBOUNCE_CYCLES, 1000000, number of stable cycles before a key change is accepted (20 ms at 50 MHz); minimum 2.
- ADDR_W, 5, Avalon word-address width; must cover 5+NUM_LEDS words.

Ports:
- clk_clk  in  1  system clock (50 MHz).
- reset_reset_n  in  1  reset, asynchronous assert, active-low.
- avs_address  in  ADDR_W  word address.
- avs_read  in  1  read strobe.
- avs_write  in  1  write strobe.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid with avs_readdatavalid.
- avs_readdatavalid  out  1  one-cycle pulse, one cycle after avs_read.
- key_n  in  NUM_KEYS  raw push-buttons, active-low, asynchronous.
- led  out  NUM_LEDS  LED drive, active-high, registered.
- irq  out  1  level interrupt, registered.

Behaviour:
- Clock and reset: clk_clk is the only clock. reset_reset_n is asynchronous and active-low.
- Values under reset:
  - led=0, irq=0, avs_readdata=0, avs_readdatavalid=0.
  - All registers are 0. Debounced key state is 0 (released).
  - Synchroniser flops are set to 1 (released).
  - Debounce counters and the PWM counter are 0.
- Reset asserted mid-operation clears all of the above immediately.
- Register map (word address, access):
  - 0 CTRL, RW: bit0 EN, bit1 MODE (0=direct, 1=PWM).
  - 1 LED_DIRECT, RW: bits NUM_LEDS-1:0.
  - 2 KEY_STATE, RO: debounced state, 1=pressed.
  - 3 EDGE_CAP, W1C: bit set on a press.
  - 4 IRQ_MASK, RW.
  - 5+i DUTY[i], RW: bits PWM_BITS-1:0, for i in 0..NUM_LEDS-1.
  - Unmapped addresses read 0; writes to them are ignored.
  - Unused upper bits read 0.
- Bus timing:
  - Read latency is fixed at 1 cycle; there is no waitrequest.
  - Write takes effect on the clock edge of avs_write.
  - Read and write to the same address in the same cycle: the read returns the pre-write value.
- Key path:
  - Each key passes through a 2-flop synchroniser and is inverted to active-high.
  - Per key, a counter of width clog2(DEBOUNCE_CYCLES) runs as follows:
    - If the synchronised input differs from the debounced state, the counter increments.
    - When the count reaches DEBOUNCE_CYCLES-1, the debounced state takes the input and the counter clears.
    - If the input equals the debounced state, the counter clears.
  - Total latency from a clean key_n edge to KEY_STATE is DEBOUNCE_CYCLES+2 cycles.
- Edge capture:
  - An EDGE_CAP bit sets on a debounced 0->1 transition. Releases are not captured.
  - Writing 1 to a bit clears it; writing 0 leaves it unchanged.
  - A set and a clear of the same bit in the same cycle leaves the bit set.
- Interrupt: irq = |(EDGE_CAP & IRQ_MASK), registered, so it lags EDGE_CAP by 1 cycle.
- PWM:
  - A free-running PWM_BITS counter wraps from 2^PWM_BITS-1 to 0.
  - Each DUTY[i] has a shadow copy, loaded only in the cycle the counter wraps to 0. This keeps periods glitch-free.
  - The PWM output for channel i is 1 when cnt < shadow[i].
    - Duty 0 gives always off.
    - Maximum duty gives on for (2^PWM_BITS-1) of every 2^PWM_BITS cycles.
  - The shadow copies load out of reset at the first wrap, which occurs 2^PWM_BITS cycles after reset deasserts.
- LED output:
  - led[i] is registered as EN & (MODE ? pwm[i] : LED_DIRECT[i]).
  - This gives 1 cycle of latency from a register update.
  - A MODE change applies on the next cycle and does not wait for a wrap.

Decomposition:
- Package led_key_pio_pkg contains:
  - Register address constants: ADDR_CTRL=0, ADDR_LED_DIRECT=1, ADDR_KEY_STATE=2, ADDR_EDGE_CAP=3, ADDR_IRQ_MASK=4, ADDR_DUTY_BASE=5.
  - CTRL bit indices: CTRL_EN=0, CTRL_MODE=1.
- Sub-module key_debounce: one synchroniser plus counter per key, parameter DEBOUNCE_CYCLES, generated NUM_KEYS times. It outputs the debounced level and a press pulse.

Test Plan:
- Reset: hold reset_reset_n low for 10 cycles with key_n=0 and writes attempted -> led=0, irq=0, readdatavalid=0. After release, KEY_STATE reads 0 until DEBOUNCE_CYCLES+2 cycles have elapsed.
- Direct mode: write CTRL=0x1, LED_DIRECT=0xA -> led=4'b1010 one cycle after the write. Write CTRL=0 -> led=0 next cycle.
- PWM (PWM_BITS=8): CTRL=0x3, DUTY0=64, DUTY1=0, DUTY2=255, DUTY3=128 -> per 256-cycle period led high for 64, 0, 255 and 128 cycles respectively. Rewriting DUTY0=32 mid-period -> the current period stays 64 and the next period is 32.
- Debounce (DEBOUNCE_CYCLES=16): 5-cycle low glitches on key_n[1] -> KEY_STATE unchanged. key_n[1] held low for 20 cycles -> KEY_STATE=0x2 and EDGE_CAP=0x2. With IRQ_MASK=0x2, irq=1 one cycle later. Releasing the key leaves EDGE_CAP unchanged.
- W1C race: write EDGE_CAP=0x1 in the exact cycle a new key0 press is captured -> EDGE_CAP bit0 stays 1 and irq stays 1. A subsequent write of 0x1 clears it and irq drops one cycle later.
- Bus edge cases: reading address 31 -> 0 with readdatavalid one cycle later. Simultaneous read and write of LED_DIRECT (old 0x3, new 0x5) -> readdata=0x3; the next read returns 0x5.
